// File: rtl/audioplay_pio_pkg.sv
// Shared constants for the audio-player button PIO: register addresses,
// edge-type encodings and the edge-event helper.
package audioplay_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_DBTHRESH = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit edge events between the current and previous debounced level
  function automatic logic [31:0] edge_events(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int          edge_type);
    logic [31:0] ev;
    ev = 32'd0;
    case (edge_type)
      EDGE_RISE: ev = cur & ~prev;
      EDGE_FALL: ev = ~cur & prev;
      EDGE_ANY:  ev = cur ^ prev;
      default:   ev = 32'd0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/audioplay_debounce_bit.sv
// One button channel: two-flop synchroniser plus optional debounce counter.
// Debounce logic present only when AUDIOPLAY_PIO_DEBOUNCE_EN is defined.
module audioplay_debounce_bit #(
  parameter int DB_CNT_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
  input  logic [DB_CNT_W-1:0] thr,
`endif
  output logic                stable
);

  logic meta_r;
  logic sync_r;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt_r;
  logic                stable_r;
  logic [DB_CNT_W:0]   cnt_inc_s;
  logic [DB_CNT_W:0]   thr_eff_s;

  // One extra bit so cnt+1 never wraps; a zero threshold behaves as one
  always_comb begin
    cnt_inc_s = {1'b0, cnt_r} + (DB_CNT_W+1)'(1);
    if (thr == '0) begin
      thr_eff_s = (DB_CNT_W+1)'(1);
    end else begin
      thr_eff_s = {1'b0, thr};
    end
  end

  // Count consecutive disagreeing cycles; adopt the new level at threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (sync_r == stable_r) begin
      cnt_r <= '0;
    end else if (cnt_inc_s >= thr_eff_s) begin
      stable_r <= sync_r;
      cnt_r    <= '0;
    end else begin
      cnt_r <= cnt_inc_s[DB_CNT_W-1:0];
    end
  end

  assign stable = stable_r;
`else
  localparam int unused_cnt_w = DB_CNT_W;

  assign stable = sync_r;
`endif

endmodule

// File: rtl/audioplay_button_pio.sv
// Avalon-MM input PIO for front-panel buttons: sync/debounce, edge capture, IRQ.
// Define AUDIOPLAY_PIO_DEBOUNCE_EN to build the debounce counters and DBTHRESH.
module audioplay_button_pio
  import audioplay_pio_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DB_CNT_W   = 20,
  parameter int DB_DEFAULT = 500000,
  parameter int EDGE_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] stable_d_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      rd_mux_s;
  logic [31:0]      readdata_r;
  logic             wr_s;
  logic             unused_wdata_s;

`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] dbthresh_r;
`else
  localparam int unused_db_cfg = DB_CNT_W + DB_DEFAULT;
`endif

  // Upper writedata bits are architecturally ignored
  assign unused_wdata_s = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    audioplay_debounce_bit #(
      .DB_CNT_W (DB_CNT_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[i]),
`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
      .thr    (dbthresh_r),
`endif
      .stable (stable_s[i])
    );
  end

  // Write decode, edge events and clear mask
  always_comb begin
    wr_s   = chipselect & write;
    edge_s = WIDTH'(edge_events(32'(stable_s), 32'(stable_d_r), EDGE_TYPE));
    if (wr_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // Read mux; unimplemented bits read as zero
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      ADDR_DATA:     rd_mux_s = 32'(stable_s);
      ADDR_IRQMASK:  rd_mux_s = 32'(irqmask_r);
`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
      ADDR_DBTHRESH: rd_mux_s = 32'(dbthresh_r);
`else
      ADDR_DBTHRESH: rd_mux_s = 32'd0;
`endif
      ADDR_EDGECAP:  rd_mux_s = 32'(edgecap_r);
      default:       rd_mux_s = 32'd0;
    endcase
  end

  // Register file; a new edge takes priority over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d_r <= '0;
      irqmask_r  <= '0;
      edgecap_r  <= '0;
      readdata_r <= 32'd0;
`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
      dbthresh_r <= DB_CNT_W'(DB_DEFAULT);
`endif
    end else begin
      stable_d_r <= stable_s;
      edgecap_r  <= (edgecap_r & ~clr_s) | edge_s;
      readdata_r <= rd_mux_s;
      if (wr_s && (address == ADDR_IRQMASK)) begin
        irqmask_r <= writedata[WIDTH-1:0];
      end
`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
      if (wr_s && (address == ADDR_DBTHRESH)) begin
        dbthresh_r <= writedata[DB_CNT_W-1:0];
      end
`endif
    end
  end

  assign readdata = readdata_r;
  assign irq      = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_audioplay_button_pio.sv
// Self-checking bench for audioplay_button_pio: directed button scenarios,
// a cycle-level behavioural model and literal expectations for key timings.
module tb_audioplay_button_pio;

`ifdef AUDIOPLAY_PIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int DB_DEFAULT = 500000;
  // cycles from an in_port step until the debounced level changes (thr=4)
  localparam int LAT = DB_EN ? 6 : 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'h0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  audioplay_button_pio #(
    .WIDTH      (4),
    .DB_CNT_W   (20),
    .DB_DEFAULT (DB_DEFAULT),
    .EDGE_TYPE  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel's debounced level follows the twice-delayed pin once the pin has
  // disagreed with it for thr consecutive cycles (or immediately without debounce).
  logic [3:0]  m_s1, m_s2, m_level, m_level_prev, m_mask, m_edge;
  int          m_run [4];
  int          m_thr;
  logic [31:0] m_rd;
  int          cyc = 0;

  function automatic int run_next(input int run, input logic pin, input logic lvl, input int t);
    if (pin == lvl) return 0;
    if (run + 1 >= t) return 0;
    return run + 1;
  endfunction

  function automatic logic level_next(input int run, input logic pin, input logic lvl,
                                      input int t, input logic pin_early);
    if (!DB_EN) return pin_early;
    if ((pin != lvl) && (run + 1 >= t)) return pin;
    return lvl;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_s1 <= 4'h0; m_s2 <= 4'h0; m_level <= 4'h0; m_level_prev <= 4'h0;
      m_mask <= 4'h0; m_edge <= 4'h0; m_rd <= 32'd0;
      m_thr <= DB_EN ? DB_DEFAULT : 0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      case (address)
        2'd0:    m_rd <= {28'd0, m_level};
        2'd1:    m_rd <= {28'd0, m_mask};
        2'd2:    m_rd <= 32'(m_thr);
        default: m_rd <= {28'd0, m_edge};
      endcase
      for (int i = 0; i < 4; i++) begin
        m_level[i] <= level_next(m_run[i], m_s2[i], m_level[i], (m_thr == 0) ? 1 : m_thr, m_s1[i]);
        m_run[i]   <= run_next(m_run[i], m_s2[i], m_level[i], (m_thr == 0) ? 1 : m_thr);
      end
      // falling-edge capture: channels that went high->low on the previous cycle
      m_edge <= (m_edge & ~((chipselect && write && address == 2'd3) ? writedata[3:0] : 4'h0))
                | (m_level_prev & ~m_level);
      if (chipselect && write && address == 2'd1) m_mask <= writedata[3:0];
      if (DB_EN && chipselect && write && address == 2'd2) m_thr <= int'(writedata & 32'h000F_FFFF);
      m_s1 <= in_port;
      m_s2 <= m_s1;
      m_level_prev <= m_level;
    end
  end

  // Compare DUT against the model on every cycle
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    @(negedge clk);
    chk(name, readdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   k;
    bit   found;
    logic last_irq;

    // reset for three cycles
    tick(3);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_data", 2'd0, 32'd0);
    rd_chk("rst_irqmask", 2'd1, 32'd0);
    rd_chk("rst_dbthresh", 2'd2, DB_EN ? 32'(DB_DEFAULT) : 32'd0);
    rd_chk("rst_edgecap", 2'd3, 32'd0);

    // configure; upper writedata bits ignored, DATA not writable
    wr_reg(2'd2, 32'hFFF0_0004);
    wr_reg(2'd1, 32'hFFFF_FFF1);
    wr_reg(2'd0, 32'h0000_000F);
    rd_chk("irqmask_trunc", 2'd1, 32'h1);
    rd_chk("dbthresh_trunc", 2'd2, DB_EN ? 32'h4 : 32'h0);
    rd_chk("data_after_wr0", 2'd0, 32'h0);

    // release all buttons: rising levels are not captured
    in_port = 4'hF;
    tick(12);
    rd_chk("data_released", 2'd0, 32'hF);
    rd_chk("edgecap_no_rise", 2'd3, 32'h0);

    // press button 0 and time the DATA change
    address = 2'd0;
    in_port = 4'hE;
    found = 1'b0; k = 0; last_irq = irq;
    while (!found && k < 20) begin
      last_irq = irq;
      @(negedge clk);
      k = k + 1;
      if (readdata[0] == 1'b0) found = 1'b1;
    end
    chk("data0_fall_latency", 32'(k), DB_EN ? 32'd7 : 32'd3);
    chk("irq_before_edge", {31'd0, last_irq}, 32'd0);
    chk("irq_with_edgecap", {31'd0, irq}, 32'd1);
    rd_chk("edgecap_bit0", 2'd3, 32'h1);

    // three-cycle glitch on button 1
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(12);
    rd_chk("data_after_glitch", 2'd0, 32'hE);
    rd_chk("edgecap_after_glitch", 2'd3, DB_EN ? 32'h1 : 32'h3);

    // real press on button 1, then write-1-to-clear
    in_port = 4'hC;
    tick(12);
    rd_chk("edgecap_two", 2'd3, 32'h3);
    wr_reg(2'd3, 32'h1);
    rd_chk("edgecap_clr0", 2'd3, 32'h2);
    wr_reg(2'd3, 32'h2);
    rd_chk("edgecap_clr1", 2'd3, 32'h0);

    // clear coinciding with a fresh bit-1 edge: the edge wins
    in_port = 4'hE;
    tick(12);
    rd_chk("edgecap_idle", 2'd3, 32'h0);
    in_port = 4'hC;
    tick(LAT);
    wr_reg(2'd3, 32'h2);
    rd_chk("edge_beats_clear", 2'd3, 32'h2);

    // collect all four edges, then exercise the mask
    in_port = 4'hD;
    tick(12);
    in_port = 4'h0;
    tick(12);
    wr_reg(2'd1, 32'h0);
    rd_chk("edgecap_all", 2'd3, 32'hF);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr_reg(2'd1, 32'h8);
    chk("irq_unmasked_next_clk", {31'd0, irq}, 32'd1);

    // reset in the middle of a debounce count
    wr_reg(2'd3, 32'hF);
    rd_chk("edgecap_cleared", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(12);
    in_port = 4'hE;
    tick(4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    rd_chk("midrst_edgecap", 2'd3, 32'h0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    rd_chk("midrst_data", 2'd0, DB_EN ? 32'h0 : 32'hE);
    rd_chk("midrst_irqmask", 2'd1, 32'h0);
    rd_chk("midrst_dbthresh", 2'd2, DB_EN ? 32'(DB_DEFAULT) : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
